// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core: sequences the shared ALU and
// unified memory port, and traps on illegal opcodes or memory-bus timeouts.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_code_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       adr_src_o,
  output logic       we_dmem_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       branch_o,
  output logic       reg_we_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic [2:0] imm_src_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALRADR, S_JUMP, S_AUIPC, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R     = 7'b0110011, OP_I     = 7'b0010011,
                         OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR  = 7'b1100111, OP_AUIPC = 7'b0010111,
                         OP_LUI   = 7'b0110111, OP_FENCE = 7'b0001111;
  // Last counter value at which a still-missing ready becomes a timeout.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            is_mem, timeout;

  assign is_mem  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout = (MEM_TIMEOUT != 0) && is_mem && !mem_ready_i && (wait_cnt == TO_LAST);
  assign state_o = state;

  always_comb begin
    state_nxt = state;
    if (timeout) state_nxt = S_TRAP;
    else begin
      case (state)
        S_RST:      state_nxt = S_FETCH;
        S_FETCH:    if (mem_ready_i) state_nxt = S_DECODE;
        S_DECODE: begin
          case (op_code_i)
            OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
            OP_R:              state_nxt = S_EXECR;
            OP_I:              state_nxt = S_EXECI;
            OP_BR:             state_nxt = S_BRANCH;
            OP_JAL:            state_nxt = S_JUMP;
            OP_JALR:           state_nxt = S_JALRADR;
            OP_AUIPC:          state_nxt = S_AUIPC;
            OP_LUI:            state_nxt = S_LUI;
            OP_FENCE:          state_nxt = S_FETCH;
            default:           state_nxt = S_TRAP;
          endcase
        end
        S_MEMADR:   state_nxt = (op_code_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready_i) state_nxt = S_MEMWB;
        S_MEMWRITE: if (mem_ready_i) state_nxt = S_FETCH;
        S_MEMWB, S_BRANCH: state_nxt = S_FETCH;
        S_EXECR, S_EXECI, S_AUIPC, S_LUI: state_nxt = S_ALUWB;
        S_ALUWB:    state_nxt = S_FETCH;
        S_JALRADR:  state_nxt = S_JUMP;
        S_JUMP:     state_nxt = S_ALUWB;
        default:    state_nxt = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_RST;
      wait_cnt  <= '0;
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      // Non-memory states hold the counter at zero, so every memory state is entered clean.
      wait_cnt <= (is_mem && !mem_ready_i) ? wait_cnt + TO_W'(1) : '0;
      if (state == S_DECODE && state_nxt == S_TRAP) illegal_o <= 1'b1;
      if (timeout) bus_err_o <= 1'b1;
    end
  end

  always_comb begin
    mem_req_o = 1'b0; adr_src_o = 1'b0; we_dmem_o = 1'b0; ir_we_o = 1'b0;
    pc_we_o = 1'b0; branch_o = 1'b0; reg_we_o = 1'b0;
    alu_src_a_o = 2'b00; alu_src_b_o = 2'b00; alu_op_o = 2'b00; result_src_o = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_o = 1'b1; alu_src_b_o = 2'b10; result_src_o = 2'b10;
        ir_we_o = mem_ready_i; pc_we_o = mem_ready_i;
      end
      S_DECODE:   begin alu_src_a_o = 2'b01; alu_src_b_o = 2'b01; end
      S_MEMADR:   begin alu_src_a_o = 2'b10; alu_src_b_o = 2'b01; end
      S_MEMREAD:  begin mem_req_o = 1'b1; adr_src_o = 1'b1; end
      S_MEMWB:    begin result_src_o = 2'b01; reg_we_o = 1'b1; end
      S_MEMWRITE: begin mem_req_o = 1'b1; adr_src_o = 1'b1; we_dmem_o = 1'b1; end
      S_EXECR:    begin alu_src_a_o = 2'b10; alu_op_o = 2'b10; end
      S_EXECI:    begin alu_src_a_o = 2'b10; alu_src_b_o = 2'b01; alu_op_o = 2'b10; end
      S_ALUWB:    reg_we_o = 1'b1;
      S_BRANCH:   begin alu_src_a_o = 2'b10; alu_op_o = 2'b01; branch_o = 1'b1; end
      S_JALRADR:  begin alu_src_a_o = 2'b10; alu_src_b_o = 2'b01; end
      S_JUMP:     begin alu_src_a_o = 2'b01; alu_src_b_o = 2'b10; pc_we_o = 1'b1; end
      S_AUIPC:    begin alu_src_a_o = 2'b01; alu_src_b_o = 2'b01; end
      S_LUI:      begin alu_src_a_o = 2'b11; alu_src_b_o = 2'b01; end
      default: ;
    endcase
  end

  always_comb begin
    imm_src_o = 3'b000;
    if (state != S_RST) begin
      case (op_code_i)
        OP_JAL:          imm_src_o = 3'b100;
        OP_AUIPC, OP_LUI: imm_src_o = 3'b011;
        OP_STORE:        imm_src_o = 3'b001;
        OP_BR:           imm_src_o = 3'b010;
        default:         imm_src_o = 3'b000;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state and control vectors
// for each instruction class, traps, and reset behaviour.
module tb_multicycle_controller;
  logic       clk_i, rst_i, mem_ready_i;
  logic [6:0] op_code_i;
  logic       mem_req_o, adr_src_o, we_dmem_o, ir_we_o, pc_we_o, branch_o, reg_we_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
  logic [2:0] imm_src_o;
  logic       illegal_o, bus_err_o;
  logic [3:0] state_o;
  logic [17:0] ctrl;

  int checks = 0, passes = 0;

  multicycle_controller #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_code_i(op_code_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .adr_src_o(adr_src_o), .we_dmem_o(we_dmem_o),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .branch_o(branch_o), .reg_we_o(reg_we_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .result_src_o(result_src_o), .imm_src_o(imm_src_o), .illegal_o(illegal_o),
    .bus_err_o(bus_err_o), .state_o(state_o)
  );

  assign ctrl = {mem_req_o, adr_src_o, we_dmem_o, ir_we_o, pc_we_o, branch_o, reg_we_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam int RST = 0, FE = 1, DE = 2, MA = 3, MR = 4, MW = 5, MWR = 6, ER = 7,
                 EI = 8, AW = 9, BR = 10, JRA = 11, JMP = 12, AUI = 13, LUI = 14, TRP = 15;
  // {mem_req adr we ir pc br reg}_a_b_aluop_res
  localparam logic [14:0] K_0    = 15'd0,
                          K_FE   = 15'b1001100_00_10_00_10,
                          K_FW   = 15'b1000000_00_10_00_10,
                          K_DE   = 15'b0000000_01_01_00_00,
                          K_MA   = 15'b0000000_10_01_00_00,
                          K_MR   = 15'b1100000_00_00_00_00,
                          K_MWB  = 15'b0000001_00_00_00_01,
                          K_MWR  = 15'b1110000_00_00_00_00,
                          K_ER   = 15'b0000000_10_00_10_00,
                          K_AW   = 15'b0000001_00_00_00_00,
                          K_BR   = 15'b0000010_10_00_01_00,
                          K_JRA  = 15'b0000000_10_01_00_00,
                          K_JMP  = 15'b0000100_01_10_00_00,
                          K_AUI  = 15'b0000000_01_01_00_00,
                          K_LUI  = 15'b0000000_11_01_00_00;

  logic [3:0]  obs_st  [0:31];
  logic [17:0] obs_ctl [0:31];
  logic        obs_ill [0:31];
  logic        obs_be  [0:31];

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Records n consecutive cycles; rdy[i] drives mem_ready_i in cycle i.
  task automatic capture(input int n, input logic [31:0] rdy);
    for (int i = 0; i < n; i++) begin
      mem_ready_i = rdy[i];
      #1;
      obs_st[i] = state_o; obs_ctl[i] = ctrl; obs_ill[i] = illegal_o; obs_be[i] = bus_err_o;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; op_code_i = 7'b0110011; mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (state_o !== 4'(RST)) $display("FAIL reset_state got %0d exp %0d", state_o, RST); else passes++;
    checks++; if (ctrl !== 18'd0) $display("FAIL reset_ctrl got %b exp 0", ctrl); else passes++;
    checks++; if ({illegal_o, bus_err_o} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {illegal_o, bus_err_o}); else passes++;
    rst_i = 1'b0;
  endtask

  task automatic test_rtype();
    int es[$]; logic [14:0] ek[$];
    es = '{RST, FE, DE, ER, AW, FE};
    ek = '{K_0, K_FE, K_DE, K_ER, K_AW, K_FE};
    op_code_i = 7'b0110011; do_reset(); capture(es.size(), 32'hFFFF_FFFF);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL rtype_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== {ek[i], 3'b000}) $display("FAIL rtype_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b000}); else passes++;
    end
  endtask

  task automatic test_load_wait();
    int es[$]; logic [14:0] ek[$];
    es = '{RST, FE, DE, MA, MR, MR, MR, MR, MW, FE};
    ek = '{K_0, K_FE, K_DE, K_MA, K_MR, K_MR, K_MR, K_MR, K_MWB, K_FE};
    op_code_i = 7'b0000011; do_reset(); capture(es.size(), ~32'h70);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL load_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== {ek[i], 3'b000}) $display("FAIL load_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b000}); else passes++;
    end
  endtask

  task automatic test_store();
    int es[$]; logic [14:0] ek[$];
    es = '{RST, FE, DE, MA, MWR, FE};
    ek = '{K_0, K_FE, K_DE, K_MA, K_MWR, K_FE};
    op_code_i = 7'b0100011; do_reset(); capture(es.size(), 32'hFFFF_FFFF);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL store_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== (es[i] == RST ? 18'd0 : {ek[i], 3'b001})) $display("FAIL store_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b001}); else passes++;
    end
    // Reset in the middle of a stalled write must drop the request at once.
    do_reset(); capture(5, ~32'h10);
    mem_ready_i = 1'b0; #1;
    checks++; if (ctrl !== {K_MWR, 3'b001}) $display("FAIL store_stall_ctrl got %b exp %b", ctrl, {K_MWR, 3'b001}); else passes++;
    rst_i = 1'b1; #1;
    checks++; if ({state_o, ctrl} !== 22'd0) $display("FAIL store_async_rst got %0d/%b exp 0/0", state_o, ctrl); else passes++;
    @(posedge clk_i); #1;
    checks++; if ({mem_req_o, we_dmem_o} !== 2'b00) $display("FAIL store_rst_hold got %b exp 00", {mem_req_o, we_dmem_o}); else passes++;
    rst_i = 1'b0;
  endtask

  task automatic test_jumps();
    int es[$]; logic [14:0] ek[$];
    es = '{RST, FE, DE, JRA, JMP, AW, FE};
    ek = '{K_0, K_FE, K_DE, K_JRA, K_JMP, K_AW, K_FE};
    op_code_i = 7'b1100111; do_reset(); capture(es.size(), 32'hFFFF_FFFF);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL jalr_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== {ek[i], 3'b000}) $display("FAIL jalr_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b000}); else passes++;
    end
    es = '{RST, FE, DE, JMP, AW, FE};
    ek = '{K_0, K_FE, K_DE, K_JMP, K_AW, K_FE};
    op_code_i = 7'b1101111; do_reset(); capture(es.size(), 32'hFFFF_FFFF);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL jal_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== (es[i] == RST ? 18'd0 : {ek[i], 3'b100})) $display("FAIL jal_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b100}); else passes++;
    end
  endtask

  task automatic test_branch();
    int es[$]; logic [14:0] ek[$];
    es = '{RST, FE, DE, BR, FE};
    ek = '{K_0, K_FE, K_DE, K_BR, K_FE};
    op_code_i = 7'b1100011; do_reset(); capture(es.size(), 32'hFFFF_FFFF);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL branch_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== (es[i] == RST ? 18'd0 : {ek[i], 3'b010})) $display("FAIL branch_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b010}); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int es[$]; logic [14:0] ek[$];
    es = '{RST, FE, DE, AUI, AW};
    ek = '{K_0, K_FE, K_DE, K_AUI, K_AW};
    op_code_i = 7'b0010111; do_reset(); capture(es.size(), 32'hFFFF_FFFF);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL auipc_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== (es[i] == RST ? 18'd0 : {ek[i], 3'b011})) $display("FAIL auipc_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b011}); else passes++;
    end
    es = '{FE, DE, LUI, AW, FE};
    ek = '{K_FE, K_DE, K_LUI, K_AW, K_FE};
    op_code_i = 7'b0110111; capture(es.size(), 32'hFFFF_FFFF);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL lui_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== {ek[i], 3'b011}) $display("FAIL lui_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b011}); else passes++;
    end
  endtask

  task automatic test_illegal();
    op_code_i = 7'b1110011; do_reset(); capture(23, 32'hFFFF_FFFF);
    for (int i = 0; i < 23; i++) begin
      checks++;
      if (obs_st[i] !== (i == 0 ? 4'(RST) : i == 1 ? 4'(FE) : i == 2 ? 4'(DE) : 4'(TRP)))
        $display("FAIL illegal_state cyc %0d got %0d", i, obs_st[i]);
      else passes++;
      checks++; if (obs_ill[i] !== (i >= 3)) $display("FAIL illegal_flag cyc %0d got %b exp %b", i, obs_ill[i], i >= 3); else passes++;
      if (i >= 3) begin
        checks++; if (obs_ctl[i] !== 18'd0) $display("FAIL illegal_ctrl cyc %0d got %b exp 0", i, obs_ctl[i]); else passes++;
      end
    end
    rst_i = 1'b1; #1;
    checks++; if ({state_o, illegal_o} !== 5'd0) $display("FAIL illegal_clear got %0d/%b exp 0/0", state_o, illegal_o); else passes++;
    @(posedge clk_i); #1; rst_i = 1'b0;
  endtask

  task automatic test_timeout();
    int es[$]; logic [14:0] ek[$];
    es = '{RST, FE, FE, FE, FE, TRP, TRP};
    ek = '{K_0, K_FW, K_FW, K_FW, K_FW, K_0, K_0};
    op_code_i = 7'b0110011; do_reset(); capture(es.size(), ~32'h1E);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL timeout_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== {ek[i], 3'b000}) $display("FAIL timeout_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b000}); else passes++;
      checks++; if ({obs_be[i], obs_ill[i]} !== {i >= 5, 1'b0}) $display("FAIL timeout_flags cyc %0d got %b%b", i, obs_be[i], obs_ill[i]); else passes++;
    end
    es = '{RST, FE, FE, FE, FE, DE};
    ek = '{K_0, K_FW, K_FW, K_FW, K_FE, K_DE};
    do_reset(); capture(es.size(), ~32'h0E);
    for (int i = 0; i < es.size(); i++) begin
      checks++; if (obs_st[i] !== 4'(es[i])) $display("FAIL ready_wins_state cyc %0d got %0d exp %0d", i, obs_st[i], es[i]); else passes++;
      checks++; if (obs_ctl[i] !== {ek[i], 3'b000}) $display("FAIL ready_wins_ctrl cyc %0d got %b exp %b", i, obs_ctl[i], {ek[i], 3'b000}); else passes++;
      checks++; if (obs_be[i] !== 1'b0) $display("FAIL ready_wins_buserr cyc %0d got %b exp 0", i, obs_be[i]); else passes++;
    end
  endtask

  initial begin
    rst_i = 1'b1; op_code_i = 7'd0; mem_ready_i = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_jumps();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM for the multi-cycle RV32I core. It shares one ALU and one unified instruction/data memory port across the execution steps of each instruction.
- Sits between the instruction register (opcode field) and the datapath. It drives mux selects, register, PC and IR write enables, and the memory request handshake.
- Detects illegal opcodes and memory-bus timeouts, and halts in a trap state when either occurs.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for mem_ready_i per access; 0 disables the timeout.
- TO_W, 8: width of the wait counter; MEM_TIMEOUT must be < 2^TO_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- op_code_i  in  7  opcode field of the instruction register.
- mem_ready_i  in  1  memory completes the current request this cycle.
- mem_req_o  out  1  memory access request; held high until mem_ready_i.
- adr_src_o  out  1  memory address source: 0 = PC, 1 = ALUOut.
- we_dmem_o  out  1  memory write strobe; valid only with mem_req_o.
- ir_we_o  out  1  load instruction register and old-PC register.
- pc_we_o  out  1  unconditional PC write.
- branch_o  out  1  datapath writes PC if the branch condition holds.
- reg_we_o  out  1  register file write.
- alu_src_a_o  out  2  ALU A select: 00 PC, 01 oldPC, 10 rs1, 11 zero.
- alu_src_b_o  out  2  ALU B select: 00 rs2, 01 imm, 10 constant 4.
- alu_op_o  out  2  ALU operation: 00 add, 01 sub (compare), 10 funct-decoded.
- result_src_o  out  2  result select: 00 ALUOut, 01 memory data, 10 ALU result.
- imm_src_o  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
- illegal_o  out  1  sticky: illegal opcode trapped.
- bus_err_o  out  1  sticky: memory timeout trapped.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset: rst_i asynchronously forces state RST and clears the wait counter, illegal_o and bus_err_o. In RST every output is 0. RST goes to FETCH on the first clock edge after reset is released.
- Default output value is 0 in every state. Only the assignments listed below are non-zero.
- imm_src_o is combinational from op_code_i in all states except RST:
  - JAL 1101111 -> 100.
  - AUIPC 0010111 and LUI 0110111 -> 011.
  - Store 0100011 -> 001.
  - Branch 1100011 -> 010.
  - All other opcodes -> 000.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - While mem_ready_i=0: stay in FETCH; ir_we and pc_we stay 0.
  - In the cycle mem_ready_i=1: ir_we=1, pc_we=1 (PC <= PC+4); go to DECODE.
- DECODE: a=01, b=01, alu_op=00, so ALUOut receives the branch/JAL target. Next state by opcode:
  - 0000011 load or 0100011 store -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JUMP.
  - 1100111 -> JALRADR.
  - 0010111 -> AUIPC.
  - 0110111 -> LUI.
  - 0001111 (FENCE) -> FETCH, treated as a NOP.
  - Any other opcode, including SYSTEM -> TRAP with illegal_o set.
- MEMADR: a=10, b=01, alu_op=00. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready_i, then go to MEMWB.
- MEMWB: result_src=01, reg_we=1; go to FETCH.
- MEMWRITE: mem_req=1, adr_src=1, we_dmem=1. Wait for mem_ready_i, then go to FETCH.
- EXECR: a=10, b=00, alu_op=10; go to ALUWB.
- EXECI: a=10, b=01, alu_op=10; go to ALUWB.
- ALUWB: result_src=00, reg_we=1; go to FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1; go to FETCH.
- JALRADR: a=10, b=01, alu_op=00, so ALUOut receives rs1+imm; go to JUMP.
- JUMP: a=01, b=10, alu_op=00, result_src=00, pc_we=1. PC receives the target; the ALU computes oldPC+4. Go to ALUWB.
- AUIPC: a=01, b=01, alu_op=00; go to ALUWB.
- LUI: a=11, b=01, alu_op=00; go to ALUWB.
- TRAP: all strobes are 0. Stay in TRAP until reset; illegal_o and bus_err_o hold their values.
- Wait counter:
  - Clears on entry to any memory state and whenever mem_ready_i=1.
  - Increments on each memory-state cycle with mem_ready_i=0.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready_i still 0: go to TRAP and set bus_err_o.
  - If mem_ready_i=1 in that same cycle, the normal transition wins.
- Instruction latency (counting the 1-cycle FETCH), assuming zero-wait memory:
  - R-type, I-type, AUIPC, LUI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
  - JALR: 5 cycles.
- Reset asserted mid-access drops mem_req_o immediately, with no partial write strobe afterwards.

Test Plan:
- Reset release, zero-wait memory, opcode 0110011 -> state sequence RST, FETCH, DECODE, EXECR, ALUWB, FETCH; reg_we=1 only in ALUWB; pc_we=1 only in the FETCH cycle.
- Load 0000011, mem_ready_i low for 3 cycles in MEMREAD -> mem_req=1 and adr_src=1 held for 4 cycles; MEMWB asserts result_src=01 and reg_we=1; total 8 cycles.
- Store 0100011 -> imm_src=001; MEMWRITE asserts we_dmem=1 with mem_req=1; reg_we never asserted.
- JALR 1100111 -> JALRADR (a=10, b=01), then JUMP (pc_we=1, a=01, b=10), then ALUWB (reg_we=1); 5 cycles. JAL 1101111 skips JALRADR and shows imm_src=100.
- Opcode 1110011 -> TRAP after DECODE; illegal_o=1 holds for 20 cycles while all strobes are 0; rst_i pulse clears illegal_o.
- MEM_TIMEOUT=4, mem_ready_i tied to 0 in FETCH -> TRAP on the 4th wait cycle with bus_err_o=1. A second run with mem_ready_i=1 on exactly that cycle goes to DECODE instead.
